// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// lc3_mem_pkg : shared types and defaults for the LC-3 memory access controller
// Revision 1.0
// ============================================================================
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam int          WAIT_CYCLES_DEF = 2;
  localparam logic [15:0] IO_ADDR_DEF     = 16'hFFFF;
  localparam int          SRAM_ADDR_W     = 20;

endpackage
`default_nettype wire

// File: rtl/io_sync.sv
`default_nettype none
// ============================================================================
// io_sync : two-flop synchronizer for the board switch bus
// Revision 1.0
// ============================================================================
module io_sync #(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/lc3_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// lc3_mem_access_ctrl : turns ISDU read/write requests into timed SRAM cycles
// with a Done handshake and switch/hex I/O at IO_ADDR. Option: MEM_IO_SWITCH_SYNC_EN
// Revision 1.0
// ============================================================================
module lc3_mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEF)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Req_Rd,
  input  logic                   Req_Wr,
  input  logic [ADDR_W-1:0]      Addr,
  input  logic [DATA_W-1:0]      Wr_Data,
  output logic [DATA_W-1:0]      Rd_Data,
  output logic                   Done,
  output logic                   Busy,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0]      SRAM_Din,
  output logic [DATA_W-1:0]      SRAM_Dout,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  input  logic [DATA_W-1:0]      Switches,
  output logic [DATA_W-1:0]      Hex_Out
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  mem_state_e             state_q;
  logic [3:0]             cnt_q;
  logic [3:0]             cnt_d;
  logic                   wr_q;
  logic [DATA_W-1:0]      rd_data_q;
  logic [DATA_W-1:0]      hex_q;
  logic                   done_q;
  logic                   busy_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0]      sram_dout_q;
  logic                   ce_n_q;
  logic                   oe_n_q;
  logic                   we_n_q;
  logic [DATA_W-1:0]      switches_w;
  logic                   req_w;
  logic                   is_io_w;

`ifdef MEM_IO_SWITCH_SYNC_EN
  io_sync #(.DATA_W(DATA_W)) u_io_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d_i   (Switches),
    .q_o   (switches_w)
  );
`else
  assign switches_w = Switches;
`endif

  assign req_w   = Req_Rd | Req_Wr;
  assign is_io_w = (Addr == IO_ADDR);
  assign cnt_d   = cnt_q + 4'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rd_data_q   <= '0;
      hex_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_w) begin
            busy_q <= 1'b1;
            if (is_io_w) begin
              // Write takes priority when both request lines are high
              if (Req_Wr) hex_q     <= Wr_Data;
              else        rd_data_q <= switches_w;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              wr_q        <= Req_Wr;
              sram_addr_q <= SRAM_ADDR_W'(Addr);
              sram_dout_q <= Wr_Data;
              cnt_q       <= '0;
              ce_n_q      <= 1'b0;
              oe_n_q      <= Req_Wr;
              we_n_q      <= !(Req_Wr && (WAIT_LAST != 4'd0));
              state_q     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q == WAIT_LAST) begin
            if (!wr_q) rd_data_q <= SRAM_Din;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q  <= cnt_d;
            // WE_N releases one cycle early so data is held past the strobe
            we_n_q <= !(wr_q && (cnt_d != WAIT_LAST));
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Rd_Data   = rd_data_q;
  assign Hex_Out   = hex_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_Dout = sram_dout_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ce_n_q;
  assign SRAM_LB_N = ce_n_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lc3_mem_access_ctrl : randomized scoreboard bench for lc3_mem_access_ctrl
// Revision 1.0
// ============================================================================
module tb_lc3_mem_access_ctrl;

  localparam int          WAIT = 2;
  localparam logic [15:0] IOA  = 16'hFFFF;

  logic        Clk, Reset, Req_Rd, Req_Wr;
  logic [15:0] Addr, Wr_Data, Rd_Data, SRAM_Din, SRAM_Dout, Switches, Hex_Out;
  logic [19:0] SRAM_ADDR;
  logic        Done, Busy, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  lc3_mem_access_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr), .Addr(Addr),
    .Wr_Data(Wr_Data), .Rd_Data(Rd_Data), .Done(Done), .Busy(Busy),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_Din(SRAM_Din), .SRAM_Dout(SRAM_Dout),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .Switches(Switches), .Hex_Out(Hex_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          busy;
    int          oe;
    int          we;
    int          ce;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    logic [15:0] hex;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_rd  = '0;
  logic [15:0] m_hex = '0;

`ifdef MEM_IO_SWITCH_SYNC_EN
  // switch value seen by a read is the one present two edges earlier
  logic [15:0] sw_h1 = '0;
  logic [15:0] sw_h2 = '0;
  initial forever begin
    @(posedge Clk);
    sw_h2 = sw_h1;
    sw_h1 = Switches;
  end
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: accumulates strobe activity between Done pulses
  int busy_c = 0, oe_c = 0, we_c = 0, ce_c = 0, bad_addr = 0, bad_dout = 0, bad_ub = 0;
  initial forever begin
    @(negedge Clk);
    if (Reset) begin
      busy_c = 0; oe_c = 0; we_c = 0; ce_c = 0; bad_addr = 0; bad_dout = 0; bad_ub = 0;
    end else begin
      if (Busy)       busy_c++;
      if (!SRAM_OE_N) oe_c++;
      if (!SRAM_WE_N) we_c++;
      if (SRAM_UB_N !== SRAM_CE_N || SRAM_LB_N !== SRAM_CE_N) bad_ub++;
      if (!SRAM_CE_N) begin
        ce_c++;
        if (exp_q.size() > 0) begin
          if (SRAM_ADDR !== {4'h0, exp_q[0].addr}) bad_addr++;
          if (exp_q[0].wr && SRAM_Dout !== exp_q[0].wdata) bad_dout++;
        end
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got Done=1 expected no pending request");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("busy_cycles", busy_c, e.busy);
          chk("oe_low_cycles", oe_c, e.oe);
          chk("we_low_cycles", we_c, e.we);
          chk("ce_low_cycles", ce_c, e.ce);
          chk("addr_unstable", bad_addr, 0);
          chk("dout_unstable", bad_dout, 0);
          chk("ub_lb_strobe", bad_ub, 0);
          chk("rd_data", {16'h0, Rd_Data}, {16'h0, e.rd});
          chk("hex_out", {16'h0, Hex_Out}, {16'h0, e.hex});
        end
        busy_c = 0; oe_c = 0; we_c = 0; ce_c = 0; bad_addr = 0; bad_dout = 0; bad_ub = 0;
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [15:0] din, input logic [15:0] sw);
    exp_t        e;
    logic        io;
    logic [15:0] swv;
    bit          got;
    @(negedge Clk);
    Switches = sw;
`ifdef MEM_IO_SWITCH_SYNC_EN
    swv = sw_h2;
`else
    swv = sw;
`endif
    io = (a == IOA);
    if (wr) begin
      if (io) m_hex = wd;
    end else if (rd) begin
      m_rd = io ? swv : din;
    end
    e.busy  = io ? 1 : WAIT + 2;
    e.ce    = io ? 0 : WAIT + 1;
    e.oe    = (!io && !wr) ? WAIT + 1 : 0;
    e.we    = (!io && wr) ? WAIT : 0;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    e.rd    = m_rd;
    e.hex   = m_hex;
    exp_q.push_back(e);
    Req_Rd = rd; Req_Wr = wr; Addr = a; Wr_Data = wd; SRAM_Din = din;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done) begin
        got = 1;
        break;
      end
      // requests raised while busy must be ignored
      Req_Rd  = 1'($urandom_range(0, 1));
      Req_Wr  = 1'($urandom_range(0, 1));
      Addr    = 16'($urandom);
      Wr_Data = 16'($urandom);
    end
    Req_Rd = 1'b0;
    Req_Wr = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no Done in 40 cycles expected Done");
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation stall expected completion");
    $fatal(1);
  end

  initial begin
    logic rd, wr;
    logic [15:0] a;
    Reset = 1'b1; Req_Rd = 0; Req_Wr = 0; Addr = '0; Wr_Data = '0; SRAM_Din = '0; Switches = '0;
    repeat (3) @(negedge Clk);
    chk("reset_rd_data", {16'h0, Rd_Data}, 32'h0);
    chk("reset_hex", {16'h0, Hex_Out}, 32'h0);
    chk("reset_done_busy", {30'h0, Done, Busy}, 32'h0);
    chk("reset_sram_addr", {12'h0, SRAM_ADDR}, 32'h0);
    chk("reset_sram_dout", {16'h0, SRAM_Dout}, 32'h0);
    chk("reset_strobes", {27'h0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
    @(posedge Clk); #1 Reset = 1'b0;

    txn(1, 0, 16'h0003, 16'h0000, 16'h1234, 16'h0000);
    txn(0, 1, 16'h0010, 16'hBEEF, 16'h5555, 16'h0000);
    txn(0, 1, IOA,      16'h00C5, 16'h0000, 16'h0000);
    txn(1, 0, IOA,      16'h0000, 16'h0000, 16'h0042);
    txn(1, 1, 16'h0020, 16'hA5A5, 16'h7777, 16'h0042);
    // switch change then back-to-back I/O reads
    txn(1, 0, IOA, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge Clk);
    txn(1, 0, IOA, 16'h0000, 16'h0000, 16'hFFFF);
    txn(1, 0, IOA, 16'h0000, 16'h0000, 16'hFFFF);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = ($urandom_range(0, 3) == 0) ? IOA : 16'($urandom_range(0, 16'hFFFE));
      txn(rd, wr, a, 16'($urandom), 16'($urandom), 16'($urandom));
      if (i == 20) begin
        // reset in the middle of an SRAM write
        @(negedge Clk);
        Req_Wr = 1'b1; Addr = 16'h0030; Wr_Data = 16'h1357;
        @(negedge Clk);
        Req_Wr = 1'b0;
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_mid_strobes", {30'h0, SRAM_WE_N, SRAM_CE_N}, 32'h3);
        chk("rst_mid_busy", {31'h0, Busy}, 32'h0);
        chk("rst_mid_rd_hex", {Rd_Data, Hex_Out}, 32'h0);
        m_rd  = '0;
        m_hex = '0;
        for (int j = 0; j < 6; j++) begin
          chk("rst_mid_no_done", {31'h0, Done}, 32'h0);
          @(negedge Clk);
        end
      end
    end

    repeat (4) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
